// File: rtl/counter_event_logger.sv
// Timestamped event FIFO between the counter stage and host wire-out/trigger-in endpoints.
// Latency: a push shows on rec_out/level one cycle later; a pop advances the head one cycle later.
// Backpressure: none upstream; pushes into a full FIFO are dropped and counted unless a pop lands in the same cycle.
module counter_event_logger #(
    parameter int DEPTH    = 8,
    parameter int TS_WIDTH = 16
) (
    input  logic                   sys_clk,
    input  logic                   rst_n,
    input  logic [2:0]             evt_in,
    input  logic [7:0]             count1,
    input  logic [7:0]             count2,
    input  logic                   pop,
    input  logic                   clear,
    output logic [31:0]            rec_out,
    output logic [$clog2(DEPTH):0] level,
    output logic                   empty,
    output logic                   full,
    output logic                   overflow,
    output logic [7:0]             ovf_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [31:0]         mem [DEPTH];
    logic [TS_WIDTH-1:0] ts;
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [AW-1:0]       rd_ptr_nxt;
    logic                push_req;
    logic                do_push;
    logic                do_pop;
    logic                drop;
    logic [7:0]          snap;
    logic [31:0]         rec_new;
    logic [LW-1:0]       level_nxt;
    logic [31:0]         rec_nxt;

    always_comb begin
        push_req   = |evt_in;
        do_pop     = pop && !empty;
        // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
        do_push    = push_req && (!full || pop);
        drop       = push_req && full && !pop;
        snap       = evt_in[2] ? count2 : count1;
        rec_new    = {ts, evt_in, 5'b0, snap};
        rd_ptr_nxt = rd_ptr + 1'b1;

        level_nxt = level;
        if (do_push && !do_pop) begin
            level_nxt = level + 1'b1;
        end else if (!do_push && do_pop) begin
            level_nxt = level - 1'b1;
        end

        // Show-ahead head: the new record bypasses memory when it becomes the head this cycle.
        rec_nxt = rec_out;
        if (level_nxt == '0) begin
            rec_nxt = '0;
        end else if (do_pop) begin
            rec_nxt = (level == LW'(1)) ? rec_new : mem[rd_ptr_nxt];
        end else if (level == '0) begin
            rec_nxt = rec_new;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= rec_new;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            ts        <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            empty     <= 1'b1;
            full      <= 1'b0;
            overflow  <= 1'b0;
            ovf_count <= '0;
            rec_out   <= '0;
        end else if (clear) begin
            ts        <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            empty     <= 1'b1;
            full      <= 1'b0;
            overflow  <= 1'b0;
            ovf_count <= '0;
            rec_out   <= '0;
        end else begin
            ts      <= ts + 1'b1;
            level   <= level_nxt;
            empty   <= (level_nxt == '0);
            full    <= (level_nxt == LW'(DEPTH));
            rec_out <= rec_nxt;
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr_nxt;
            end
            if (drop) begin
                overflow <= 1'b1;
                if (ovf_count != 8'hFF) begin
                    ovf_count <= ovf_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_counter_event_logger.sv
// Directed bench for counter_event_logger: each task drives one scenario and checks inline.
module tb_counter_event_logger;

    logic        sys_clk = 1'b0;
    logic        rst_n   = 1'b0;
    logic [2:0]  evt_in  = '0;
    logic [7:0]  count1  = '0;
    logic [7:0]  count2  = '0;
    logic        pop     = 1'b0;
    logic        clear   = 1'b0;
    logic [31:0] rec_out;
    logic [3:0]  level;
    logic        empty;
    logic        full;
    logic        overflow;
    logic [7:0]  ovf_count;

    int          tests = 0;
    int          fails = 0;
    logic [15:0] exp_ts = '0;
    logic [31:0] q [$];

    counter_event_logger #(.DEPTH(8), .TS_WIDTH(16)) dut (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .evt_in    (evt_in),
        .count1    (count1),
        .count2    (count2),
        .pop       (pop),
        .clear     (clear),
        .rec_out   (rec_out),
        .level     (level),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .ovf_count (ovf_count)
    );

    always #5 sys_clk = ~sys_clk;

    // Timestamp model follows the clear strobe seen at each edge.
    task automatic tick();
        @(posedge sys_clk);
        if (clear) exp_ts = '0;
        else       exp_ts = exp_ts + 16'd1;
        #1;
    endtask

    task automatic push_one(input logic [7:0] c1);
        evt_in = 3'b001;
        count1 = c1;
        q.push_back({exp_ts, 3'b001, 5'b0, c1});
        tick();
        evt_in = '0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        tests++; if (empty !== 1'b1 || level !== 4'd0 || full !== 1'b0) begin
            fails++; $display("FAIL reset_flags: got empty=%b level=%0d full=%b expected 1/0/0", empty, level, full);
        end
        tests++; if (rec_out !== 32'h0 || overflow !== 1'b0 || ovf_count !== 8'd0) begin
            fails++; $display("FAIL reset_rec: got rec=%h ovf=%b cnt=%0d expected 0/0/0", rec_out, overflow, ovf_count);
        end
        rst_n  = 1'b1;
        exp_ts = '0;
        for (int i = 0; i < 5; i++) push_one(8'(i));
        tests++; if (level !== 4'd5) begin
            fails++; $display("FAIL pre_reset_level: got %0d expected 5", level);
        end
        @(negedge sys_clk);
        rst_n = 1'b0;
        #1;
        tests++; if (empty !== 1'b1 || level !== 4'd0 || rec_out !== 32'h0 || dut.ts !== 16'h0) begin
            fails++; $display("FAIL async_reset: got empty=%b level=%0d rec=%h ts=%h expected 1/0/0/0", empty, level, rec_out, dut.ts);
        end
        q.delete();
        @(posedge sys_clk);
        #1;
        rst_n  = 1'b1;
        exp_ts = '0;
        tick();
        evt_in = 3'b001;
        count1 = 8'h5A;
        tick();
        evt_in = '0;
        tests++; if (rec_out !== 32'h0001_205A || level !== 4'd1) begin
            fails++; $display("FAIL post_reset_push: got rec=%h level=%0d expected 0001205a/1", rec_out, level);
        end
        pop = 1'b1;
        tick();
        pop = 1'b0;
    endtask

    task automatic test_single();
        do_clear();
        while (exp_ts != 16'h0123) tick();
        evt_in = 3'b010;
        count1 = 8'h80;
        count2 = 8'h33;
        tick();
        evt_in = '0;
        tests++; if (rec_out !== 32'h0123_4080 || level !== 4'd1 || empty !== 1'b0) begin
            fails++; $display("FAIL single_rec: got rec=%h level=%0d empty=%b expected 01234080/1/0", rec_out, level, empty);
        end
        pop = 1'b1;
        tick();
        pop = 1'b0;
        tests++; if (empty !== 1'b1 || rec_out !== 32'h0 || level !== 4'd0) begin
            fails++; $display("FAIL single_pop: got empty=%b rec=%h level=%0d expected 1/0/0", empty, rec_out, level);
        end
    endtask

    task automatic test_merged();
        logic [15:0] ts_push;
        ts_push = exp_ts;
        evt_in  = 3'b101;
        count1  = 8'h00;
        count2  = 8'hFF;
        tick();
        evt_in = '0;
        tests++; if (rec_out !== {ts_push, 16'hA0FF} || level !== 4'd1) begin
            fails++; $display("FAIL merged_rec: got rec=%h level=%0d expected %h/1", rec_out, level, {ts_push, 16'hA0FF});
        end
        pop = 1'b1;
        tick();
        pop = 1'b0;
    endtask

    task automatic test_overflow();
        do_clear();
        for (int i = 0; i < 7; i++) push_one(8'(8'h10 + i));
        tests++; if (full !== 1'b0 || level !== 4'd7) begin
            fails++; $display("FAIL seven_full: got full=%b level=%0d expected 0/7", full, level);
        end
        push_one(8'h17);
        tests++; if (full !== 1'b1 || level !== 4'd8 || overflow !== 1'b0) begin
            fails++; $display("FAIL eight_full: got full=%b level=%0d ovf=%b expected 1/8/0", full, level, overflow);
        end
        evt_in = 3'b001;
        count1 = 8'hCC;
        tick();
        tests++; if (overflow !== 1'b1 || ovf_count !== 8'd1) begin
            fails++; $display("FAIL first_drop: got ovf=%b cnt=%0d expected 1/1", overflow, ovf_count);
        end
        repeat (299) tick();
        evt_in = '0;
        tests++; if (full !== 1'b1 || overflow !== 1'b1 || ovf_count !== 8'd255 || level !== 4'd8) begin
            fails++; $display("FAIL saturate: got full=%b ovf=%b cnt=%0d level=%0d expected 1/1/255/8", full, overflow, ovf_count, level);
        end
        for (int i = 0; i < 8; i++) begin
            tests++; if (rec_out !== q[0]) begin
                fails++; $display("FAIL drain_%0d: got %h expected %h", i, rec_out, q[0]);
            end
            void'(q.pop_front());
            pop = 1'b1;
            tick();
            pop = 1'b0;
        end
        tests++; if (empty !== 1'b1 || rec_out !== 32'h0) begin
            fails++; $display("FAIL drain_empty: got empty=%b rec=%h expected 1/0", empty, rec_out);
        end
        do_clear();
        tests++; if (overflow !== 1'b0 || ovf_count !== 8'd0 || dut.ts !== exp_ts || exp_ts !== 16'h0) begin
            fails++; $display("FAIL ovf_clear: got ovf=%b cnt=%0d ts=%h expected 0/0/0", overflow, ovf_count, dut.ts);
        end
    endtask

    task automatic test_simultaneous();
        logic [31:0] rec;
        do_clear();
        for (int i = 0; i < 8; i++) push_one(8'(8'h40 + i));
        rec    = {exp_ts, 3'b001, 5'b0, 8'hEE};
        evt_in = 3'b001;
        count1 = 8'hEE;
        pop    = 1'b1;
        tick();
        evt_in = '0;
        pop    = 1'b0;
        void'(q.pop_front());
        q.push_back(rec);
        tests++; if (level !== 4'd8 || full !== 1'b1 || overflow !== 1'b0 || ovf_count !== 8'd0) begin
            fails++; $display("FAIL full_pushpop: got level=%0d full=%b ovf=%b cnt=%0d expected 8/1/0/0", level, full, overflow, ovf_count);
        end
        tests++; if (rec_out !== q[0]) begin
            fails++; $display("FAIL full_pushpop_head: got %h expected %h", rec_out, q[0]);
        end
        do_clear();
        rec    = {exp_ts, 3'b001, 5'b0, 8'h77};
        evt_in = 3'b001;
        count1 = 8'h77;
        pop    = 1'b1;
        tick();
        evt_in = '0;
        pop    = 1'b0;
        tests++; if (level !== 4'd1 || empty !== 1'b0 || rec_out !== rec) begin
            fails++; $display("FAIL empty_pushpop: got level=%0d empty=%b rec=%h expected 1/0/%h", level, empty, rec_out, rec);
        end
        for (int i = 0; i < 7; i++) push_one(8'(i));
        clear  = 1'b1;
        evt_in = 3'b100;
        count2 = 8'h99;
        tick();
        clear  = 1'b0;
        evt_in = '0;
        q.delete();
        tests++; if (level !== 4'd0 || empty !== 1'b1 || ovf_count !== 8'd0 || overflow !== 1'b0 || rec_out !== 32'h0) begin
            fails++; $display("FAIL clear_push: got level=%0d empty=%b cnt=%0d ovf=%b rec=%h expected 0/1/0/0/0", level, empty, ovf_count, overflow, rec_out);
        end
    endtask

    task automatic test_wrap();
        int zero_hits;
        zero_hits = 0;
        while (exp_ts != 16'hFFEC) tick();
        for (int i = 0; i < 40; i++) begin
            if (q.size() >= 3) begin
                tests++; if (rec_out !== q[0]) begin
                    fails++; $display("FAIL wrap_%0d: got %h expected %h", i, rec_out, q[0]);
                end else if (q[0][31:16] == 16'h0) begin
                    zero_hits++;
                end
                void'(q.pop_front());
                pop = 1'b1;
            end
            evt_in = 3'b001;
            count1 = 8'(i);
            q.push_back({exp_ts, 3'b001, 5'b0, 8'(i)});
            tick();
            evt_in = '0;
            pop    = 1'b0;
        end
        tests++; if (level !== 4'(q.size())) begin
            fails++; $display("FAIL wrap_level: got %0d expected %0d", level, q.size());
        end
        while (q.size() > 0) begin
            tests++; if (rec_out !== q[0]) begin
                fails++; $display("FAIL wrap_drain: got %h expected %h", rec_out, q[0]);
            end
            void'(q.pop_front());
            pop = 1'b1;
            tick();
            pop = 1'b0;
        end
        tests++; if (zero_hits !== 1 || empty !== 1'b1) begin
            fails++; $display("FAIL wrap_ts_zero: got hits=%0d empty=%b expected 1/1", zero_hits, empty);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_merged();
        test_overflow();
        test_simultaneous();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
